// File: rtl/alu_share_arb_pkg.sv
// Shared constants, FSM encoding and payload type for the two-requester ALU arbiter.
package alu_share_arb_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CTRL_W  = 4;
  localparam int unsigned NUM_REQ = 2;

  // ALU operation codes
  localparam logic [CTRL_W-1:0] OP_AND  = 4'd0;
  localparam logic [CTRL_W-1:0] OP_OR   = 4'd1;
  localparam logic [CTRL_W-1:0] OP_ADD  = 4'd2;
  localparam logic [CTRL_W-1:0] OP_SUB  = 4'd3;
  localparam logic [CTRL_W-1:0] OP_SLTU = 4'd4;
  localparam logic [CTRL_W-1:0] OP_NOR  = 4'd5;

  // First code that has no ALU meaning; everything from here up is illegal
  localparam logic [CTRL_W-1:0] OP_ILLEGAL_MIN = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Operation captured on a request handshake
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [CTRL_W-1:0] ctrl;
  } op_t;

  function automatic logic op_illegal(input logic [CTRL_W-1:0] ctrl);
    return (ctrl >= OP_ILLEGAL_MIN);
  endfunction

endpackage

// File: rtl/alu_share_arb_alu.sv
// Existing 32-bit combinational ALU: and, or, add, sub, unsigned less-than, nor.
module alu
  import alu_share_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] res_c,
  output logic              zero_c
);

  // Operation select; arithmetic wraps modulo 2^32, unknown codes yield zero
  always_comb begin
    res_c = '0;
    case (ctrl)
      OP_AND:  res_c = a & b;
      OP_OR:   res_c = a | b;
      OP_ADD:  res_c = a + b;
      OP_SUB:  res_c = a - b;
      OP_SLTU: res_c = DATA_W'(a < b);
      OP_NOR:  res_c = ~(a | b);
      default: res_c = '0;
    endcase
    zero_c = (res_c == '0);
  end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one ALU between two requesters (IDLE -> EXEC -> RESP).
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter logic RR_INIT = 1'b0
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req_valid,
  output logic [NUM_REQ-1:0]  req_ready,
  input  logic [DATA_W-1:0]   req_a0,
  input  logic [DATA_W-1:0]   req_b0,
  input  logic [DATA_W-1:0]   req_a1,
  input  logic [DATA_W-1:0]   req_b1,
  input  logic [CTRL_W-1:0]   req_ctrl0,
  input  logic [CTRL_W-1:0]   req_ctrl1,
  output logic [NUM_REQ-1:0]  rsp_valid,
  input  logic [NUM_REQ-1:0]  rsp_ready,
  output logic [DATA_W-1:0]   rsp_res,
  output logic                rsp_zero,
  output logic                rsp_err,
  output logic                busy
);

  state_t              state_q;
  logic                ptr_q;
  logic                gnt_q;
  op_t                 op_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [DATA_W-1:0]   rsp_res_q;
  logic                rsp_zero_q;
  logic                rsp_err_q;
  logic                busy_q;

  logic                gnt_c;
  logic                req_hs_c;
  op_t                 op_in_c;
  logic [DATA_W-1:0]   alu_res_c;
  logic                alu_zero_c;

  // Grant choice: a lone requester wins outright, a tie goes to the pointer
  always_comb begin
    gnt_c = ptr_q;
    if (req_valid == 2'b01) begin
      gnt_c = 1'b0;
    end else if (req_valid == 2'b10) begin
      gnt_c = 1'b1;
    end
    req_ready = '0;
    if (!rst && (state_q == IDLE) && (req_valid != '0)) begin
      req_ready[gnt_c] = 1'b1;
    end
    req_hs_c = |(req_valid & req_ready);
  end

  // Operand mux feeding the capture register
  always_comb begin
    op_in_c = '0;
    if (gnt_c) begin
      op_in_c.a    = req_a1;
      op_in_c.b    = req_b1;
      op_in_c.ctrl = req_ctrl1;
    end else begin
      op_in_c.a    = req_a0;
      op_in_c.b    = req_b0;
      op_in_c.ctrl = req_ctrl0;
    end
  end

  alu u_alu (
    .a      (op_q.a),
    .b      (op_q.b),
    .ctrl   (op_q.ctrl),
    .res_c  (alu_res_c),
    .zero_c (alu_zero_c)
  );

  // FSM, capture registers and registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= RR_INIT;
      gnt_q       <= 1'b0;
      op_q        <= '0;
      rsp_valid_q <= '0;
      rsp_res_q   <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_hs_c) begin
            op_q    <= op_in_c;
            gnt_q   <= gnt_c;
            state_q <= EXEC;
            busy_q  <= 1'b1;
          end
        end
        EXEC: begin
          state_q     <= RESP;
          rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
          // Illegal codes bypass the ALU so the result is a defined constant
          if (op_illegal(op_q.ctrl)) begin
            rsp_res_q  <= '0;
            rsp_zero_q <= 1'b1;
            rsp_err_q  <= 1'b1;
          end else begin
            rsp_res_q  <= alu_res_c;
            rsp_zero_q <= alu_zero_c;
            rsp_err_q  <= 1'b0;
          end
        end
        RESP: begin
          if (rsp_ready[gnt_q]) begin
            state_q     <= IDLE;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            ptr_q       <= ~gnt_q;
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= '0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: doc/alu_share_arb.md
ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 Parameter RR_INIT, default 0, the requester holding priority after reset (0 or 1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid[1:0]  input  2  per-requester operation request.
REQ-005 req_ready[1:0]  output  2  per-requester accept; handshake when valid and ready are both high.
REQ-006 req_a0, req_b0, req_a1, req_b1  input  32 each  operands of requester 0 and requester 1.
REQ-007 req_ctrl0, req_ctrl1  input  4 each  ALU operation code (0 and, 1 or, 2 add, 3 sub, 4 unsigned less-than, 5 nor).
REQ-008 rsp_valid[1:0]  output  2  per-requester result valid.
REQ-009 rsp_ready[1:0]  input  2  per-requester result accept.
REQ-010 rsp_res  output  32  registered result, shared by both response channels.
REQ-011 rsp_zero  output  1  registered flag, high when rsp_res is 0.
REQ-012 rsp_err  output  1  registered flag, high when the operation code was illegal.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-015 In IDLE, if exactly one req_valid is high, that requester SHALL be granted.
REQ-016 In IDLE, if both req_valid are high, the requester named by the priority pointer SHALL be granted.
REQ-017 In IDLE, req_ready SHALL be combinationally high for the granted requester only, and zero when no valid is high.
REQ-018 On a handshake, the arbiter SHALL latch operands, ctrl and grant ID, then move to EXEC.
REQ-019 req_ready SHALL be 0 in EXEC and RESP; new requests wait and are not dropped.
REQ-020 In EXEC, the latched operands SHALL drive the single ALU instance.
REQ-021 In EXEC, result and zero flag SHALL be registered and the FSM SHALL move to RESP.
REQ-022 In RESP, rsp_valid SHALL be high for the granted ID only.
REQ-023 In RESP, rsp_res, rsp_zero and rsp_err SHALL stay stable until rsp_ready of the granted ID is high.
REQ-024 On that response handshake, the FSM SHALL return to IDLE and the priority pointer SHALL move to the other requester.
REQ-025 rsp_ready of the non-granted requester SHALL be ignored.
REQ-026 Latency SHALL be fixed: request handshake in cycle N gives rsp_valid in cycle N+2.
REQ-027 Peak throughput SHALL be one operation per 3 cycles when the response is accepted at once.
REQ-028 Arithmetic SHALL be 32-bit modulo 2^32, with no carry or overflow output.
REQ-029 Less-than (ctrl 4) SHALL be an unsigned compare.
REQ-030 For ctrl 6..15, the arbiter SHALL register rsp_res=0, rsp_zero=1, rsp_err=1 and bypass the ALU output, so no X value is ever registered.
REQ-031 rsp_err SHALL be 0 for legal codes.
REQ-032 If a requester withdraws req_valid in IDLE before a handshake, no state SHALL change.
REQ-033 If only the non-priority requester is valid, it SHALL still be granted at once.

Reset
REQ-034 While rst is high at a clock edge: state=IDLE, pointer=RR_INIT, rsp_valid=0, rsp_res=0, rsp_zero=0, rsp_err=0, busy=0.
REQ-035 Reset in EXEC or RESP SHALL discard the in-flight operation, and no response SHALL be produced for it.
REQ-036 req_ready SHALL be 0 during the cycle rst is high.

Structure
REQ-037 A shared package SHALL hold the ALU op-code constants (AND..NOR), the illegal-code limit and the FSM state encoding.
REQ-038 Exactly one sub-module, alu (the existing 32-bit ALU), SHALL be instantiated once inside this block.
REQ-039 All other logic (arbiter, FSM, result registers) SHALL be local to this block.

Verification
REQ-040 Single request: after reset, req_valid=01, a0=5, b0=3, ctrl0=2 -> rsp_valid=01 two cycles after handshake, rsp_res=8, zero=0, err=0.
REQ-041 Simultaneous requests with RR_INIT=0: req_valid=11, ctrl0=3 (7-7), ctrl1=1 (0xF0|0x0F) -> requester 0 first (res=0, zero=1), then requester 1 (res=0xFF), with pointer alternating on the next tie.
REQ-042 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_res stable, req_ready=00 throughout, release completes the operation.
REQ-043 Illegal op: ctrl=4'hA -> rsp_res=0, rsp_zero=1, rsp_err=1, no X on any output.
REQ-044 Compare and wrap: a=0xFFFFFFFF, b=1, ctrl=4 -> res=0; ctrl=2 -> res=0, zero=1.
REQ-045 Reset in EXEC: assert rst one cycle -> no rsp_valid, busy=0, pointer=RR_INIT, next request handled normally.
